// File: rtl/byte_word_packer_pkg.sv
// byte_word_packer_pkg: shared lane-count limits, default pad, fill-index type and lane mapping
package byte_word_packer_pkg;
  localparam int MIN_WORD_BYTES = 2;
  localparam int MAX_WORD_BYTES = 8;
  localparam logic [7:0] DEF_PAD_BYTE = 8'h00;
  typedef logic [2:0] idx_t;
  function automatic idx_t lane_sel(input idx_t idx, input bit big_endian, input int word_bytes);
    return big_endian ? idx_t'(word_bytes - 1 - int'(idx)) : idx;
  endfunction
endpackage

// File: rtl/byte_word_packer_outreg.sv
// byte_word_packer_outreg: output word register with valid/ready handshake, word counter under BYTE_WORD_PACKER_CNT_EN
module byte_word_packer_outreg #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [8*WORD_BYTES-1:0] data_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  input  logic                    last_i,
  input  logic                    out_ready_i,
  output logic                    slot_free_o,
  output logic                    out_valid_o,
  output logic [8*WORD_BYTES-1:0] out_data_o,
  output logic [WORD_BYTES-1:0]   out_be_o,
  output logic                    out_last_o
`ifdef BYTE_WORD_PACKER_CNT_EN
  ,
  output logic [31:0]             word_cnt_o
`endif
);
  assign slot_free_o = !out_valid_o || out_ready_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_be_o    <= '0;
      out_last_o  <= 1'b0;
    end else if (load_i) begin
      out_valid_o <= 1'b1;
      out_data_o  <= data_i;
      out_be_o    <= be_i;
      out_last_o  <= last_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
`ifdef BYTE_WORD_PACKER_CNT_EN
  always_ff @(posedge clk_i)
    if (rst_i) word_cnt_o <= '0;
    else if (out_valid_o && out_ready_i) word_cnt_o <= word_cnt_o + 32'd1;
`endif
endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a byte stream into WORD_BYTES-wide words with flush/pad, word counter under BYTE_WORD_PACKER_CNT_EN
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter int         BIG_ENDIAN = 0,
  parameter logic [7:0] PAD_BYTE   = DEF_PAD_BYTE
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [8*WORD_BYTES-1:0] out_data_o,
  output logic [WORD_BYTES-1:0]   out_be_o,
  output logic                    out_last_o
`ifdef BYTE_WORD_PACKER_CNT_EN
  ,
  output logic [31:0]             word_cnt_o
`endif
);
  localparam idx_t LAST = idx_t'(WORD_BYTES - 1);
  idx_t cnt;
  logic pend, slot_free, acc, fire, full, load;
  logic [7:0] hold [MAX_WORD_BYTES];
  logic [8*WORD_BYTES-1:0] word;
  logic [WORD_BYTES-1:0] be;
  assign in_ready_o = !rst_i && !pend && !(cnt == LAST && !slot_free);
  assign acc = in_valid_i && in_ready_o;
  assign fire = (flush_i || pend) && slot_free;
  assign full = acc && cnt == LAST;
  assign load = full || (fire && (acc || cnt != '0));
  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    localparam idx_t I = idx_t'(g);
    localparam int L = int'(lane_sel(I, BIG_ENDIAN != 0, WORD_BYTES));
    assign be[L] = I < cnt || (I == cnt && acc);
    assign word[8*L +: 8] = I < cnt ? hold[I] : (I == cnt && acc) ? in_data_i : PAD_BYTE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      cnt  <= (full || fire) ? '0 : cnt + idx_t'(acc);
      pend <= (flush_i || pend) && !slot_free;
    end
  always_ff @(posedge clk_i)
    if (acc) hold[cnt] <= in_data_i;
  byte_word_packer_outreg #(.WORD_BYTES(WORD_BYTES)) u_outreg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .data_i      (word),
    .be_i        (be),
    .last_i      (fire),
    .out_ready_i (out_ready_i),
    .slot_free_o (slot_free),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_be_o    (out_be_o),
    .out_last_o  (out_last_o)
`ifdef BYTE_WORD_PACKER_CNT_EN
    ,
    .word_cnt_o  (word_cnt_o)
`endif
  );
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: randomized and directed bench for two packer configurations against a queue-based model
module tb_byte_word_packer;
  localparam int WB = 4;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst, in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic rdy0, rdy1, v0, v1, l0, l1;
  logic [31:0] d0, d1;
  logic [3:0] b0, b1;
`ifdef BYTE_WORD_PACKER_CNT_EN
  logic [31:0] c0, c1;
`endif
  int checks = 0, failures = 0;
  bq_t fill, obytes;
  bit pend, ov, olast;
  int unsigned wcnt;
  always #5 clk = ~clk;
  byte_word_packer #(.WORD_BYTES(4), .BIG_ENDIAN(0), .PAD_BYTE(8'hFF)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy0),
    .flush_i(flush), .out_valid_o(v0), .out_ready_i(out_ready), .out_data_o(d0), .out_be_o(b0),
    .out_last_o(l0)
`ifdef BYTE_WORD_PACKER_CNT_EN
    , .word_cnt_o(c0)
`endif
  );
  byte_word_packer #(.WORD_BYTES(4), .BIG_ENDIAN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy1),
    .flush_i(flush), .out_valid_o(v1), .out_ready_i(out_ready), .out_data_o(d1), .out_be_o(b1),
    .out_last_o(l1)
`ifdef BYTE_WORD_PACKER_CNT_EN
    , .word_cnt_o(c1)
`endif
  );
  function automatic logic [31:0] exp_data(input bq_t q, input bit be, input logic [7:0] pad);
    logic [31:0] d = '0;
    for (int i = 0; i < WB; i++) d[8*(be ? WB-1-i : i) +: 8] = (i < q.size()) ? q[i] : pad;
    return d;
  endfunction
  function automatic logic [3:0] exp_be(input bq_t q, input bit be);
    logic [3:0] m = '0;
    for (int i = 0; i < q.size(); i++) m[be ? WB-1-i : i] = 1'b1;
    return m;
  endfunction
  function automatic bit model_ready();
    return !rst && !pend && !(fill.size() == WB-1 && ov && !out_ready);
  endfunction
  task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r);
    in_valid = v;
    in_data = d;
    flush = f;
    out_ready = r;
    #1;
  endtask
  task automatic tick();
    bit acc, slot, fl;
    slot = !ov || out_ready;
    acc = in_valid && model_ready();
    if (rst) begin
      fill.delete();
      obytes.delete();
      pend = 0;
      ov = 0;
      olast = 0;
      wcnt = 0;
    end else begin
      fl = (flush || pend) && slot;
      if (ov && out_ready) begin
        ov = 0;
        wcnt++;
      end
      if (acc) fill.push_back(in_data);
      if (fill.size() == WB || (fl && fill.size() > 0)) begin
        obytes = fill;
        olast = fl;
        ov = 1;
        fill.delete();
      end
      pend = (flush || pend) && !slot;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    drive(1, 8'h5A, 0, 1);
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b/%b want=0", rdy0, rdy1); end
    tick();
    tick();
    checks++;
    if (v0 !== 1'b0 || l0 !== 1'b0 || b0 !== 4'h0 || d0 !== 32'h0)
      begin failures++; $display("FAIL reset_state0 got v=%b l=%b be=%h d=%h want all 0", v0, l0, b0, d0); end
    checks++;
    if (v1 !== 1'b0 || l1 !== 1'b0 || b1 !== 4'h0 || d1 !== 32'h0)
      begin failures++; $display("FAIL reset_state1 got v=%b l=%b be=%h d=%h want all 0", v1, l1, b1, d1); end
    rst = 0;
    drive(0, 8'h00, 0, 1);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b/%b want=1", rdy0, rdy1); end
    tick();
  endtask
  task automatic test_basic();
    logic [7:0] s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, s[i], 0, 1);
      tick();
      if (i < 3) begin
        checks++;
        if (v0 !== 1'b0) begin failures++; $display("FAIL basic_early_valid byte=%0d got=%b want=0", i, v0); end
      end
    end
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'h44332211 || b0 !== 4'hF || l0 !== 1'b0)
      begin failures++; $display("FAIL basic_le got v=%b d=%h be=%h l=%b want 1 44332211 f 0", v0, d0, b0, l0); end
    checks++;
    if (v1 !== 1'b1 || d1 !== 32'h11223344 || b1 !== 4'hF || l1 !== 1'b0)
      begin failures++; $display("FAIL basic_be got v=%b d=%h be=%h l=%b want 1 11223344 f 0", v1, d1, b1, l1); end
    drive(0, 8'h00, 0, 1);
    tick();
    checks++;
    if (v0 !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b want=0", v0); end
  endtask
  task automatic test_flush();
    drive(1, 8'hAA, 0, 1);
    tick();
    drive(1, 8'hBB, 0, 1);
    tick();
    drive(0, 8'h00, 1, 1);
    tick();
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'hFFFFBBAA || b0 !== 4'h3 || l0 !== 1'b1)
      begin failures++; $display("FAIL flush_le got v=%b d=%h be=%h l=%b want 1 ffffbbaa 3 1", v0, d0, b0, l0); end
    checks++;
    if (v1 !== 1'b1 || d1 !== 32'hAABB0000 || b1 !== 4'hC || l1 !== 1'b1)
      begin failures++; $display("FAIL flush_be got v=%b d=%h be=%h l=%b want 1 aabb0000 c 1", v1, d1, b1, l1); end
    drive(0, 8'h00, 0, 1);
    tick();
  endtask
  task automatic test_flush_empty();
    drive(0, 8'h00, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 0, 1);
      checks++;
      if (v0 !== 1'b0 || v1 !== 1'b0) begin failures++; $display("FAIL flush_empty cyc=%0d got=%b/%b want=0", i, v0, v1); end
      tick();
    end
  endtask
  task automatic test_flush_with_byte();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'(i), 0, 1);
      tick();
    end
    drive(1, 8'h04, 1, 1);
    tick();
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'h04030201 || b0 !== 4'hF || l0 !== 1'b1)
      begin failures++; $display("FAIL flush_full got v=%b d=%h be=%h l=%b want 1 04030201 f 1", v0, d0, b0, l0); end
    drive(1, 8'h05, 1, 1);
    tick();
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'hFFFFFF05 || b0 !== 4'h1 || l0 !== 1'b1)
      begin failures++; $display("FAIL flush_one_le got v=%b d=%h be=%h l=%b want 1 ffffff05 1 1", v0, d0, b0, l0); end
    checks++;
    if (d1 !== 32'h05000000 || b1 !== 4'h8 || l1 !== 1'b1)
      begin failures++; $display("FAIL flush_one_be got d=%h be=%h l=%b want 05000000 8 1", d1, b1, l1); end
    drive(0, 8'h00, 0, 1);
    tick();
  endtask
  task automatic test_back_to_back_stall();
    logic [31:0] got[$];
    int k = 0, n = 0, blocked = 0, dut_low = 0;
    bit r;
    while (got.size() < 2 && n < 40) begin
      r = !(ov && got.size() == 0 && blocked < 3);
      drive(k < 8, 8'(k + 1), 0, r);
      checks++;
      if (rdy0 !== model_ready() || rdy1 !== model_ready())
        begin failures++; $display("FAIL stall_ready cyc=%0d got=%b/%b want=%b", n, rdy0, rdy1, model_ready()); end
      if (!r) begin
        checks++;
        if (d0 !== 32'h04030201 || v0 !== 1'b1)
          begin failures++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h want 1 04030201", n, v0, d0); end
        if (!model_ready()) blocked++;
        if (rdy0 === 1'b0) dut_low++;
      end
      if (k < 8 && model_ready()) k++;
      if (v0 && out_ready) got.push_back(d0);
      tick();
      n++;
    end
    checks++;
    if (dut_low != 3) begin failures++; $display("FAIL stall_blocked got=%0d cycles want=3", dut_low); end
    checks++;
    if (got.size() != 2) begin failures++; $display("FAIL stall_count got=%0d want=2", got.size()); end
    else begin
      checks++;
      if (got[0] !== 32'h04030201 || got[1] !== 32'h08070605)
        begin failures++; $display("FAIL stall_order got=%h,%h want=04030201,08070605", got[0], got[1]); end
    end
    drive(0, 8'h00, 0, 1);
    tick();
  endtask
  task automatic test_reset_mid();
    logic [31:0] got[$];
    drive(1, 8'hA1, 0, 1);
    tick();
    drive(1, 8'hA2, 0, 1);
    tick();
    rst = 1;
    drive(1, 8'hA3, 0, 1);
    checks++;
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_mid_ready got=%b want=0", rdy0); end
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 8'(i + 1), 0, 1);
      if (v0 && out_ready) got.push_back(d0);
      tick();
    end
    checks++;
    if (got.size() != 1) begin failures++; $display("FAIL reset_mid_count got=%0d want=1", got.size()); end
    else begin
      checks++;
      if (got[0] !== 32'h04030201) begin failures++; $display("FAIL reset_mid_word got=%h want=04030201", got[0]); end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (rdy0 !== model_ready() || rdy1 !== model_ready())
        begin failures++; $display("FAIL rand_ready cyc=%0d got=%b/%b want=%b", n, rdy0, rdy1, model_ready()); end
      tick();
      checks++;
      if (v0 !== ov || v1 !== ov) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b/%b want=%b", n, v0, v1, ov); end
      if (ov) begin
        checks++;
        if (d0 !== exp_data(obytes, 0, 8'hFF) || b0 !== exp_be(obytes, 0) || l0 !== olast)
          begin failures++; $display("FAIL rand_word_le cyc=%0d got d=%h be=%h l=%b want d=%h be=%h l=%b", n, d0, b0, l0, exp_data(obytes, 0, 8'hFF), exp_be(obytes, 0), olast); end
        checks++;
        if (d1 !== exp_data(obytes, 1, 8'h00) || b1 !== exp_be(obytes, 1) || l1 !== olast)
          begin failures++; $display("FAIL rand_word_be cyc=%0d got d=%h be=%h l=%b want d=%h be=%h l=%b", n, d1, b1, l1, exp_data(obytes, 1, 8'h00), exp_be(obytes, 1), olast); end
      end
`ifdef BYTE_WORD_PACKER_CNT_EN
      checks++;
      if (c0 !== wcnt || c1 !== wcnt) begin failures++; $display("FAIL rand_word_cnt cyc=%0d got=%0d/%0d want=%0d", n, c0, c1, wcnt); end
`endif
    end
    rst = 0;
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    in_data = 0;
    flush = 0;
    out_ready = 1;
    test_reset();
    test_basic();
    test_flush();
    test_flush_empty();
    test_flush_with_byte();
    test_back_to_back_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 Parameter WORD_BYTES, default 4, bytes per output word; legal range 2..8.
REQ-002 Parameter BIG_ENDIAN, default 0, lane order: 0 = first byte in bits [7:0]; 1 = first byte in the top byte.
REQ-003 Parameter PAD_BYTE, default 8'h00, value written to unfilled lanes of a flushed partial word.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 in_valid_i  input  1  in_data_i carries a byte.
REQ-007 in_data_i  input  8  input byte.
REQ-008 in_ready_o  output  1  packer accepts a byte this cycle.
REQ-009 flush_i  input  1  single-cycle request to emit the current partial word.
REQ-010 out_valid_o  output  1  out_data_o, out_be_o and out_last_o are valid.
REQ-011 out_ready_i  input  1  consumer accepts the word.
REQ-012 out_data_o  output  8*WORD_BYTES  packed word.
REQ-013 out_be_o  output  WORD_BYTES  per-lane byte enable; 1 = lane holds real data.
REQ-014 out_last_o  output  1  word was produced by a flush.

Function
REQ-015 A byte is accepted on any edge where in_valid_i and in_ready_o are both 1.
REQ-016 Accepted bytes fill lanes in arrival order. Fill index cnt runs 0..WORD_BYTES-1, and the lane is chosen per BIG_ENDIAN.
REQ-017 Accepting the byte at cnt = WORD_BYTES-1 does three things on the same edge: the word moves to the output register, cnt wraps to 0, and out_valid_o = 1 on the next cycle with out_be_o all ones and out_last_o = 0.
REQ-018 Latency: out_valid_o rises exactly 1 cycle after the last byte of a word is accepted.
REQ-019 in_ready_o = 0 only when cnt = WORD_BYTES-1, out_valid_o = 1, out_ready_i = 0, or a flush is pending. Otherwise in_ready_o = 1.
REQ-020 Draining the output register and loading a new word on the same edge is supported with no bubble, so sustained throughput is 1 byte per cycle.
REQ-021 out_data_o, out_be_o and out_last_o are stable while out_valid_o = 1 and out_ready_i = 0.
REQ-022 flush_i sets a sticky pend flag. The flush executes on the first edge where the output slot is free (out_valid_o = 0 or out_ready_i = 1).
REQ-023 Executing a flush with cnt > 0 does the following: unfilled lanes are loaded with PAD_BYTE, out_be_o marks only the filled lanes, out_last_o = 1, cnt resets to 0, and pend clears.
REQ-024 Executing a flush with cnt = 0 and no byte accepted that edge emits nothing and clears pend.
REQ-025 A byte accepted on the same edge a flush executes is included in the flushed word. If that byte completes the word, out_be_o is all ones and out_last_o = 1.
REQ-026 flush_i asserted while pend = 1 is absorbed into the pending flush.

Reset
REQ-027 While rst_i = 1 at an edge, the block returns to this state: cnt = 0, pend = 0, out_valid_o = 0, out_last_o = 0, out_be_o = 0, out_data_o = 0.
REQ-028 in_ready_o = 0 during reset cycles and 1 on the first cycle after reset deasserts.
REQ-029 Reset mid-word discards the partial word and any held output word; no residual word is emitted.

Configuration
REQ-030 Macro BYTE_WORD_PACKER_CNT_EN.
- Defined: adds output word_cnt_o, 32 bits, which increments on every output handshake, wraps modulo 2^32, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Structure
REQ-031 Shared package byte_word_packer_pkg holds the following:
- the WORD_BYTES legal-range constants;
- the default PAD_BYTE;
- the fill-index typedef sized for 8 lanes.
REQ-032 The lane-select function (index plus BIG_ENDIAN to lane) lives in the package.
REQ-033 One sub-module, byte_word_packer_outreg, holds the output register and its valid/ready handshake.

Verification
REQ-034 WORD_BYTES=4, BIG_ENDIAN=0, bytes 11,22,33,44, out_ready_i=1 -> one cycle after byte 44, out_data_o=32'h44332211 and out_be_o=4'hF.
REQ-035 Same stream with BIG_ENDIAN=1 -> out_data_o=32'h11223344.
REQ-036 Bytes AA,BB then flush_i, PAD_BYTE=8'hFF -> out_data_o=32'hFFFFBBAA, out_be_o=4'h3, out_last_o=1.
REQ-037 8 bytes back-to-back with out_ready_i=0 for 3 cycles after the first word -> in_ready_o=0 while stalled, first word held stable, both words delivered in order with no byte lost.
REQ-038 rst_i after 2 bytes, then bytes 01..04 -> only 32'h04030201 emitted; the pre-reset bytes are never seen.
REQ-039 Flush with cnt=0 -> out_valid_o stays 0. With BYTE_WORD_PACKER_CNT_EN defined, word_cnt_o steps exactly once per handshake.
